// File: rtl/fp_mult_pkg.sv
// Shared single-precision field widths, result-class flags and the classifier
// used when a product is captured into the result FIFO.
package fp_mult_pkg;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;
   localparam int FP_W     = 1 + FP_EXP_W + FP_MAN_W;

   typedef struct packed {
      logic nan;
      logic inf;
      logic zero;
   } fp_class_t;

   // Denormals deliberately fall through with no flag set.
   function automatic fp_class_t classify(input logic [FP_W-1:0] x);
      logic [FP_EXP_W-1:0] exp_f;
      logic [FP_MAN_W-1:0] man_f;
      fp_class_t           c;
      exp_f  = x[FP_W-2 -: FP_EXP_W];
      man_f  = x[FP_MAN_W-1:0];
      c.nan  = (&exp_f) && (man_f != '0);
      c.inf  = (&exp_f) && (man_f == '0);
      c.zero = (exp_f == '0) && (man_f == '0);
      return c;
   endfunction

endpackage

// File: rtl/fp_mult_res_fifo.sv
// Result FIFO: power-of-two ring buffer with wrap-around pointers and an
// occupancy count; the head reads as zero while empty.
module fp_mult_res_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     aclr,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_rd;

   assign do_rd = rd_en && (count_q != '0);

   // NOTE: storage has no reset; only pointers and count do, and the head is
   // masked while empty so stale contents never reach the output.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_data;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (wr_en && !do_rd)      count_d = count_q + CW'(1);
      else if (!wr_en && do_rd) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // The upstream credit scheme makes a write into a full buffer unreachable.
   always_ff @(posedge clk) begin
      if (!aclr) assert (!(wr_en && (count_q == CW'(DEPTH))));
   end

   assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count   = count_q;

endmodule

// File: rtl/fp_mult_stream_ctrl.sv
// Streams operand pairs into an external fixed-latency FP multiplier and
// buffers classified products in order, with credit-based input flow control.
module fp_mult_stream_ctrl
   import fp_mult_pkg::*;
#(
   parameter int MULT_LAT = 3,
   parameter int DEPTH    = 8
) (
   input  logic                   clk,
   input  logic                   aclr,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [FP_W-1:0]        in_a,
   input  logic [FP_W-1:0]        in_b,
   output logic [FP_W-1:0]        mult_ay,
   output logic [FP_W-1:0]        mult_az,
   output logic                   mult_ena,
   input  logic [FP_W-1:0]        mult_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FP_W-1:0]        out_data,
   output logic [2:0]             out_flags,
   output logic [$clog2(DEPTH):0] level
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int RW = FP_W + 3;

   logic [FP_W-1:0]   ay_q, ay_d, az_q, az_d;
   logic [MULT_LAT:0] vpipe_q, vpipe_d;
   logic [CW-1:0]     level_q, level_d, fifo_count;
   logic              in_ready_q, in_ready_d;
   logic              accept, pop, capture;
   fp_class_t         cap_class;
   logic [RW-1:0]     head;

   assign accept    = in_valid && in_ready_q;
   assign pop       = out_valid && out_ready;
   assign capture   = vpipe_q[MULT_LAT];
   assign cap_class = classify(mult_result);

   // Bit 0 marks a valid pair in the operand register; bits 1..MULT_LAT follow
   // it through the multiplier stages, so capture lands MULT_LAT+1 edges later.
   always_comb begin
      ay_d    = ay_q;
      az_d    = az_q;
      level_d = level_q;
      if (accept) begin
         ay_d = in_a;
         az_d = in_b;
      end
      vpipe_d = {vpipe_q[MULT_LAT-1:0], accept};
      if (accept && !pop)      level_d = level_q + CW'(1);
      else if (!accept && pop) level_d = level_q - CW'(1);
      in_ready_d = (level_d < CW'(DEPTH));
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         ay_q       <= '0;
         az_q       <= '0;
         vpipe_q    <= '0;
         level_q    <= '0;
         in_ready_q <= 1'b0;
      end else begin
         ay_q       <= ay_d;
         az_q       <= az_d;
         vpipe_q    <= vpipe_d;
         level_q    <= level_d;
         in_ready_q <= in_ready_d;
      end
   end

   fp_mult_res_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) u_res_fifo (
      .clk     (clk),
      .aclr    (aclr),
      .wr_en   (capture),
      .wr_data ({cap_class, mult_result}),
      .rd_en   (pop),
      .rd_data (head),
      .count   (fifo_count)
   );

   assign in_ready  = in_ready_q;
   assign mult_ay   = ay_q;
   assign mult_az   = az_q;
   assign mult_ena  = 1'b1;
   assign out_valid = (fifo_count != '0);
   assign out_data  = head[FP_W-1:0];
   assign out_flags = head[RW-1 -: 3];
   assign level     = level_q;

endmodule
